ofdm_tx_symbol_framer: RTL and testbench
========================================

# ofdm_tx_symbol_framer

Transmit-side counterpart of the OFDM RX path. It sits between the TX IFFT output and the DAC/channel model and buffers raw time-domain symbols of raw_symbol_length_g complex samples in a two-bank ping-pong memory. It emits each symbol with a cyclic prefix prepended, one sample every osr_g clocks, and groups sequence_length_g symbols into a frame. Its output stream matches the sample format the RX path consumes (I/Q of sample_bit_width_g plus a one-cycle valid strobe), so it can drive the RX bench loopback directly.

## Interface
- sample_bit_width_g, 12, signed width of each I and Q sample
- symbol_length_g, 320, output samples per symbol including cyclic prefix
- raw_symbol_length_g, 256, samples per raw symbol; CP length = symbol_length_g - raw_symbol_length_g (64)
- osr_g, 4, clock cycles per output sample (≥1)
- sequence_length_g, 20, symbols per frame

- sys_clk  in  1  system clock, all logic on rising edge
- sys_rstn  in  1  asynchronous active-low reset
- sys_init  in  1  synchronous clear, same effect as reset, priority over all other inputs
- in_data_i  in  sample_bit_width_g  raw symbol sample, real part
- in_data_q  in  sample_bit_width_g  raw symbol sample, imaginary part
- in_data_valid  in  1  sample offered
- in_ready  out  1  write bank free; sample accepted when in_data_valid and in_ready are both high
- tx_data_i  out  sample_bit_width_g  output sample, real part
- tx_data_q  out  sample_bit_width_g  output sample, imaginary part
- tx_data_valid  out  1  one-cycle strobe, tx_data_i/q valid
- tx_frame_start  out  1  high together with the first tx_data_valid of a frame
- tx_busy  out  1  frame in progress
- tx_underrun  out  1  one-cycle pulse, frame aborted because the next symbol was not ready

## Operation
- Reset and sys_init: both banks empty, write bank 0, read bank 0, state IDLE, all counters 0. Outputs: tx_data_i/q 0, tx_data_valid 0, tx_frame_start 0, tx_busy 0, tx_underrun 0, in_ready 1.
- Write side: accepted samples are written to the write bank at index 0..raw_symbol_length_g-1. When index raw_symbol_length_g-1 is accepted, the bank is marked full and the write bank toggles. in_ready = write bank not full.
- States:
  - IDLE: when the read bank is full, go to TX. Symbol counter = 0, tx_busy = 1, frame_start pending.
  - TX: a divider counts 0..osr_g-1. At each wrap, one read is issued at address p. Output position n runs 0..symbol_length_g-1. For n < CP, p = raw_symbol_length_g - CP + n; otherwise p = n - CP.
  - When n = symbol_length_g-1 is read, the read bank is marked empty (writable the next cycle) and the read bank toggles. The symbol counter increments.
  - If the counter reaches sequence_length_g, go to IDLE.
  - Otherwise, if the new read bank is full, continue without a gap.
  - Otherwise, pulse tx_underrun in the cycle after the last read and go to IDLE. The partially written bank is kept.
- Samples pass unmodified. No scaling or saturation is applied.
- Simultaneous write to one bank and read from the other is legal. Read and write of the same bank cannot occur, because a full bank is never written and an empty bank is never read.
- A bank is freed and written again in the same cycle only after it has been marked empty at a prior edge.

## Timing
- Memory read is registered. tx_data_i/q/valid are asserted in the cycle after the read issue and held for exactly one cycle. tx_data_i/q hold their last value between strobes.
- Start latency: the last raw sample is accepted at edge k. Bank full at k, TX entered at k+1, first read issued at k+1, first tx_data_valid in the cycle after edge k+2.
- Strobe spacing: exactly osr_g cycles, including across symbol boundaries within a frame.
- Symbol duration: symbol_length_g·osr_g cycles (1280 at defaults). Frame duration: sequence_length_g times that (25600).
- tx_busy falls in the cycle after the final tx_data_valid, or together with tx_underrun.
- Asynchronous reset mid-frame clears everything immediately. Outputs take their reset values with no further strobes.

## Test plan
- Single frame of 20 symbols, ramp data (symbol s sample m = s·256+m, Q = -I), input always valid:
  - exactly 6400 strobes, each 4 cycles apart;
  - tx_frame_start on the first strobe only;
  - each symbol's samples 0..63 equal raw 192..255, samples 64..319 equal raw 0..255;
  - tx_busy low after the final strobe.
- Backpressure: drive continuous in_data_valid. in_ready must drop after 512 accepted samples and rise one cycle after each symbol's last read. No sample is lost or duplicated.
- Underrun: supply 3 symbols, then stop. After symbol 2's final strobe, tx_underrun pulses once, tx_busy drops, and no further strobes occur. Then supply the remaining symbols: a new frame starts with tx_frame_start.
- osr_g=1 build: strobes every cycle, 320 consecutive valid cycles per symbol, no gap between symbols.
- sys_init asserted mid-symbol 5: outputs zero next cycle, in_ready 1, banks empty. A new full symbol then produces the first strobe 2 cycles after its last accept.
- sys_rstn pulsed low mid-frame: asynchronous clear, all outputs at reset values. After release, normal frame operation resumes.

Source files
------------

// File: rtl/ofdm_tx_symbol_framer.sv
`timescale 1ns/1ps
// OFDM TX symbol framer: ping-pong buffers raw IFFT symbols and replays
// each with a cyclic prefix, one sample every osr_g clocks, framed in sequences.
module ofdm_tx_symbol_framer #(
    parameter int sample_bit_width_g  = 12,
    parameter int symbol_length_g     = 320,
    parameter int raw_symbol_length_g = 256,
    parameter int osr_g               = 4,
    parameter int sequence_length_g   = 20
) (
    input  logic                          sys_clk,
    input  logic                          sys_rstn,
    input  logic                          sys_init,
    input  logic [sample_bit_width_g-1:0] in_data_i,
    input  logic [sample_bit_width_g-1:0] in_data_q,
    input  logic                          in_data_valid,
    output logic                          in_ready,
    output logic [sample_bit_width_g-1:0] tx_data_i,
    output logic [sample_bit_width_g-1:0] tx_data_q,
    output logic                          tx_data_valid,
    output logic                          tx_frame_start,
    output logic                          tx_busy,
    output logic                          tx_underrun
);

    localparam int W  = sample_bit_width_g;
    localparam int CP = symbol_length_g - raw_symbol_length_g;
    localparam int AW = (raw_symbol_length_g > 1) ? $clog2(raw_symbol_length_g) : 1;
    localparam int NW = (symbol_length_g > 1) ? $clog2(symbol_length_g) : 1;
    localparam int DW = (osr_g > 1) ? $clog2(osr_g) : 1;
    localparam int SW = $clog2(sequence_length_g + 1);

    localparam logic [NW-1:0] N_LAST = NW'(symbol_length_g - 1);
    localparam logic [NW-1:0] N_CP   = NW'(CP);
    localparam logic [AW-1:0] A_OFS  = AW'(raw_symbol_length_g - CP);
    localparam logic [AW-1:0] A_LAST = AW'(raw_symbol_length_g - 1);
    localparam logic [DW-1:0] D_LAST = DW'(osr_g - 1);
    localparam logic [SW-1:0] S_END  = SW'(sequence_length_g);

    typedef enum logic {IDLE, TX} state_t;

    state_t          state_q, state_d;
    logic [1:0]      full_q, full_d;
    logic            wr_bank_q, wr_bank_d;
    logic            rd_bank_q, rd_bank_d;
    logic [AW-1:0]   wr_idx_q, wr_idx_d;
    logic [DW-1:0]   div_q, div_d;
    logic [NW-1:0]   n_q, n_d;
    logic [SW-1:0]   sym_q, sym_d;
    logic            busy_q, busy_d;
    logic            underrun_q, underrun_d;
    logic            valid_q, valid_d;
    logic            fstart_q, fstart_d;
    logic [W-1:0]    tx_i_q, tx_i_d;
    logic [W-1:0]    tx_q_q, tx_q_d;

    logic [2*W-1:0]  mem_q [2][raw_symbol_length_g];

    logic            wr_en;
    logic            issue;
    logic [AW-1:0]   rd_addr;
    logic [2*W-1:0]  rd_word;
    logic [SW-1:0]   sym_inc;

    assign in_ready       = ~full_q[wr_bank_q];
    assign wr_en          = in_data_valid & in_ready & ~sys_init;
    assign tx_data_i      = tx_i_q;
    assign tx_data_q      = tx_q_q;
    assign tx_data_valid  = valid_q;
    assign tx_frame_start = fstart_q;
    assign tx_busy        = busy_q;
    assign tx_underrun    = underrun_q;

    // The prefix replays the tail of the raw symbol, then the whole symbol follows.
    assign rd_addr = (n_q < N_CP) ? AW'(n_q) + A_OFS : AW'(n_q - N_CP);
    assign rd_word = mem_q[rd_bank_q][rd_addr];
    assign sym_inc = sym_q + 1'b1;
    assign issue   = (state_q == TX) && (div_q == '0);

    always_ff @(posedge sys_clk) begin
        if (wr_en) begin
            mem_q[wr_bank_q][wr_idx_q] <= {in_data_i, in_data_q};
        end
    end

    always_comb begin
        state_d    = state_q;
        full_d     = full_q;
        wr_bank_d  = wr_bank_q;
        rd_bank_d  = rd_bank_q;
        wr_idx_d   = wr_idx_q;
        div_d      = div_q;
        n_d        = n_q;
        sym_d      = sym_q;
        busy_d     = busy_q;
        underrun_d = 1'b0;
        valid_d    = 1'b0;
        fstart_d   = 1'b0;
        tx_i_d     = tx_i_q;
        tx_q_d     = tx_q_q;

        if (wr_en) begin
            if (wr_idx_q == A_LAST) begin
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = ~wr_bank_q;
                wr_idx_d          = '0;
            end else begin
                wr_idx_d = wr_idx_q + 1'b1;
            end
        end

        unique case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (full_q[rd_bank_q]) begin
                    state_d = TX;
                    busy_d  = 1'b1;
                    sym_d   = '0;
                    n_d     = '0;
                    div_d   = '0;
                end
            end
            TX: begin
                div_d = (div_q == D_LAST) ? '0 : div_q + 1'b1;
                if (issue) begin
                    valid_d  = 1'b1;
                    tx_i_d   = rd_word[2*W-1:W];
                    tx_q_d   = rd_word[W-1:0];
                    fstart_d = (n_q == '0) && (sym_q == '0);
                    if (n_q == N_LAST) begin
                        full_d[rd_bank_q] = 1'b0;
                        rd_bank_d         = ~rd_bank_q;
                        n_d               = '0;
                        sym_d             = sym_inc;
                        // busy stays up one more cycle so it covers the final strobe
                        if (sym_inc == S_END) begin
                            state_d = IDLE;
                        end else if (!full_q[~rd_bank_q]) begin
                            state_d    = IDLE;
                            busy_d     = 1'b0;
                            underrun_d = 1'b1;
                        end
                    end else begin
                        n_d = n_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (sys_init) begin
            state_d    = IDLE;
            full_d     = '0;
            wr_bank_d  = 1'b0;
            rd_bank_d  = 1'b0;
            wr_idx_d   = '0;
            div_d      = '0;
            n_d        = '0;
            sym_d      = '0;
            busy_d     = 1'b0;
            underrun_d = 1'b0;
            valid_d    = 1'b0;
            fstart_d   = 1'b0;
            tx_i_d     = '0;
            tx_q_d     = '0;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rstn) begin
        if (!sys_rstn) begin
            state_q    <= IDLE;
            full_q     <= '0;
            wr_bank_q  <= 1'b0;
            rd_bank_q  <= 1'b0;
            wr_idx_q   <= '0;
            div_q      <= '0;
            n_q        <= '0;
            sym_q      <= '0;
            busy_q     <= 1'b0;
            underrun_q <= 1'b0;
            valid_q    <= 1'b0;
            fstart_q   <= 1'b0;
            tx_i_q     <= '0;
            tx_q_q     <= '0;
        end else begin
            state_q    <= state_d;
            full_q     <= full_d;
            wr_bank_q  <= wr_bank_d;
            rd_bank_q  <= rd_bank_d;
            wr_idx_q   <= wr_idx_d;
            div_q      <= div_d;
            n_q        <= n_d;
            sym_q      <= sym_d;
            busy_q     <= busy_d;
            underrun_q <= underrun_d;
            valid_q    <= valid_d;
            fstart_q   <= fstart_d;
            tx_i_q     <= tx_i_d;
            tx_q_q     <= tx_q_d;
        end
    end

endmodule

// File: tb/tb_ofdm_tx_symbol_framer.sv
`timescale 1ns/1ps
// Scoreboard bench for ofdm_tx_symbol_framer: default build plus a small osr_g=1 build.
module tb_ofdm_tx_symbol_framer;

    localparam int W    = 12;
    localparam int SYM  = 320;
    localparam int RAW  = 256;
    localparam int CP   = SYM - RAW;
    localparam int OSR  = 4;
    localparam int SEQ  = 20;
    localparam int CSYM = 20;
    localparam int CRAW = 16;
    localparam int CCP  = CSYM - CRAW;
    localparam int CSEQ = 3;

    typedef struct packed {
        logic [W-1:0] i;
        logic [W-1:0] q;
        logic         fs;
        logic         last;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         sys_rstn, sys_init;
    logic [W-1:0] in_data_i, in_data_q;
    logic         in_data_valid, in_ready;
    logic [W-1:0] tx_data_i, tx_data_q;
    logic         tx_data_valid, tx_frame_start, tx_busy, tx_underrun;

    logic [W-1:0] c_in_i, c_in_q;
    logic         c_in_valid, c_in_ready;
    logic [W-1:0] c_tx_i, c_tx_q;
    logic         c_tx_valid, c_tx_fs, c_tx_busy, c_tx_underrun;

    ofdm_tx_symbol_framer dut (
        .sys_clk(clk), .sys_rstn(sys_rstn), .sys_init(sys_init),
        .in_data_i(in_data_i), .in_data_q(in_data_q),
        .in_data_valid(in_data_valid), .in_ready(in_ready),
        .tx_data_i(tx_data_i), .tx_data_q(tx_data_q),
        .tx_data_valid(tx_data_valid), .tx_frame_start(tx_frame_start),
        .tx_busy(tx_busy), .tx_underrun(tx_underrun)
    );

    ofdm_tx_symbol_framer #(
        .sample_bit_width_g(W), .symbol_length_g(CSYM),
        .raw_symbol_length_g(CRAW), .osr_g(1), .sequence_length_g(CSEQ)
    ) dut_c (
        .sys_clk(clk), .sys_rstn(sys_rstn), .sys_init(sys_init),
        .in_data_i(c_in_i), .in_data_q(c_in_q),
        .in_data_valid(c_in_valid), .in_ready(c_in_ready),
        .tx_data_i(c_tx_i), .tx_data_q(c_tx_q),
        .tx_data_valid(c_tx_valid), .tx_frame_start(c_tx_fs),
        .tx_busy(c_tx_busy), .tx_underrun(c_tx_underrun)
    );

    int   checks = 0, errors = 0;
    int   cyc = 0;
    exp_t exp_q[$];
    exp_t c_exp[$];
    int   strobes = 0, frame_starts = 0, underruns = 0;
    int   first_fs_cyc = 0, last_strobe_cyc = 0, last_acc_cyc = 0;
    int   accepts = 0, first_block_acc = -1, frame_pos = 0;
    logic last_strobe_busy = 1'b0;
    bit   abort = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // scoreboard pop side for the default build
    always @(negedge clk) begin
        exp_t me;
        if (sys_rstn === 1'b1) begin
            checks++;
            if (tx_frame_start && !tx_data_valid) begin
                errors++;
                $display("FAIL frame_start_alone got fs=1 valid=0 want fs=0");
            end
            if (tx_underrun) underruns++;
            if (tx_data_valid) begin
                strobes++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_strobe got i=%0h q=%0h want no strobe", tx_data_i, tx_data_q);
                end else begin
                    me = exp_q.pop_front();
                    if ({tx_data_i, tx_data_q, tx_frame_start} !== {me.i, me.q, me.fs}) begin
                        errors++;
                        $display("FAIL sample got i=%0h q=%0h fs=%0b want i=%0h q=%0h fs=%0b",
                                 tx_data_i, tx_data_q, tx_frame_start, me.i, me.q, me.fs);
                    end
                    if (me.fs) begin
                        frame_starts++;
                        first_fs_cyc = cyc;
                    end else begin
                        checks++;
                        if (cyc - last_strobe_cyc != OSR) begin
                            errors++;
                            $display("FAIL strobe_spacing got %0d want %0d", cyc - last_strobe_cyc, OSR);
                        end
                    end
                    if (me.last) begin
                        checks++;
                        if (in_ready !== 1'b1) begin
                            errors++;
                            $display("FAIL in_ready_after_symbol got %b want 1", in_ready);
                        end
                    end
                end
                last_strobe_cyc  = cyc;
                last_strobe_busy = tx_busy;
            end
        end
    end

    task automatic send_syms(input int s0, input int ns);
        logic [W-1:0] raw [RAW];
        exp_t e;
        int   wc;
        for (int s = s0; s < s0 + ns; s++) begin
            for (int m = 0; m < RAW; m++) begin
                raw[m] = W'(s * RAW + m);
                wc = 0;
                forever begin
                    @(negedge clk);
                    if (abort) return;
                    in_data_i     = raw[m];
                    in_data_q     = -raw[m];
                    in_data_valid = 1'b1;
                    if (in_ready) begin
                        accepts++;
                        last_acc_cyc = cyc + 1;
                        break;
                    end
                    if (first_block_acc < 0) first_block_acc = accepts;
                    wc++;
                    if (wc > 5000) begin
                        errors++;
                        $display("FAIL feed_timeout got in_ready=0 for %0d cycles want 1", wc);
                        in_data_valid = 1'b0;
                        return;
                    end
                end
            end
            for (int n = 0; n < SYM; n++) begin
                e.i    = (n < CP) ? raw[RAW - CP + n] : raw[n - CP];
                e.q    = -e.i;
                e.fs   = (n == 0) && (frame_pos == 0);
                e.last = (n == SYM - 1);
                exp_q.push_back(e);
            end
            frame_pos = (frame_pos + 1) % SEQ;
        end
        @(negedge clk);
        in_data_valid = 1'b0;
    endtask

    task automatic test_reset();
        sys_rstn = 1'b0; sys_init = 1'b0;
        in_data_valid = 1'b0; in_data_i = '0; in_data_q = '0;
        c_in_valid = 1'b0; c_in_i = '0; c_in_q = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({tx_data_valid, tx_frame_start, tx_busy, tx_underrun} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags got %b want 0000", {tx_data_valid, tx_frame_start, tx_busy, tx_underrun});
        end
        sys_rstn = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({tx_data_i, tx_data_q} !== '0) begin
            errors++;
            $display("FAIL reset_data got %0h want 0", {tx_data_i, tx_data_q});
        end
        checks++;
        if (in_ready !== 1'b1 || c_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready got %b%b want 11", in_ready, c_in_ready);
        end
        checks++;
        if (tx_busy !== 1'b0 || tx_data_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle got busy=%b valid=%b want 0 0", tx_busy, tx_data_valid);
        end
    endtask

    task automatic test_frame();
        int s0, f0, u0;
        s0 = strobes; f0 = frame_starts; u0 = underruns;
        frame_pos = 0; first_block_acc = -1; accepts = 0;
        send_syms(0, SEQ);
        for (int c = 0; c < 30000 && strobes - s0 < SEQ * SYM; c++) @(posedge clk);
        @(negedge clk);
        checks++;
        if (tx_busy !== 1'b0) begin
            errors++;
            $display("FAIL frame_busy_end got %b want 0", tx_busy);
        end
        checks++;
        if (last_strobe_busy !== 1'b1) begin
            errors++;
            $display("FAIL frame_busy_last got %b want 1", last_strobe_busy);
        end
        checks++;
        if (strobes - s0 != SEQ * SYM) begin
            errors++;
            $display("FAIL frame_strobes got %0d want %0d", strobes - s0, SEQ * SYM);
        end
        checks++;
        if (frame_starts - f0 != 1) begin
            errors++;
            $display("FAIL frame_starts got %0d want 1", frame_starts - f0);
        end
        checks++;
        if (first_block_acc != 2 * RAW) begin
            errors++;
            $display("FAIL backpressure_accepts got %0d want %0d", first_block_acc, 2 * RAW);
        end
        checks++;
        if (last_strobe_cyc - first_fs_cyc != (SEQ * SYM - 1) * OSR) begin
            errors++;
            $display("FAIL frame_duration got %0d want %0d", last_strobe_cyc - first_fs_cyc, (SEQ * SYM - 1) * OSR);
        end
        repeat (50) @(negedge clk);
        checks++;
        if (underruns != u0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL frame_tail got underruns=%0d left=%0d want 0 0", underruns - u0, exp_q.size());
        end
    endtask

    task automatic test_underrun();
        int s0, f0, u0, ucnt, ucyc, s1;
        logic ubusy;
        s0 = strobes; f0 = frame_starts; u0 = underruns;
        ucnt = 0; ucyc = -1; ubusy = 1'b1;
        frame_pos = 0;
        send_syms(0, 3);
        for (int c = 0; c < 8000 && strobes - s0 < 3 * SYM; c++) begin
            @(negedge clk);
            if (tx_underrun) begin ucnt++; ucyc = cyc; ubusy = tx_busy; end
        end
        repeat (20) begin
            @(negedge clk);
            if (tx_underrun) begin ucnt++; ucyc = cyc; ubusy = tx_busy; end
        end
        checks++;
        if (ucnt != 1) begin
            errors++;
            $display("FAIL underrun_pulses got %0d want 1", ucnt);
        end
        checks++;
        if (ucyc != last_strobe_cyc) begin
            errors++;
            $display("FAIL underrun_timing got cyc %0d want %0d", ucyc, last_strobe_cyc);
        end
        checks++;
        if (ubusy !== 1'b0) begin
            errors++;
            $display("FAIL underrun_busy got %b want 0", ubusy);
        end
        s1 = strobes;
        repeat (1500) @(negedge clk);
        checks++;
        if (strobes != s1 || s1 - s0 != 3 * SYM) begin
            errors++;
            $display("FAIL underrun_silence got %0d strobes want %0d", strobes - s0, 3 * SYM);
        end
        frame_pos = 0;
        send_syms(3, 2);
        for (int c = 0; c < 8000 && strobes - s0 < 5 * SYM; c++) @(posedge clk);
        repeat (20) @(negedge clk);
        checks++;
        if (frame_starts - f0 != 2 || underruns - u0 != 2) begin
            errors++;
            $display("FAIL underrun_restart got fs=%0d ur=%0d want 2 2", frame_starts - f0, underruns - u0);
        end
    endtask

    task automatic test_init();
        int s0, f0;
        s0 = strobes;
        frame_pos = 0; abort = 1'b0;
        fork
            send_syms(0, SEQ);
        join_none
        for (int c = 0; c < 20000 && strobes - s0 < 5 * SYM + 100; c++) @(posedge clk);
        @(posedge clk);
        #1;
        sys_init = 1'b1; abort = 1'b1; in_data_valid = 1'b0;
        @(posedge clk);
        #1;
        exp_q.delete();
        @(negedge clk);
        checks++;
        if ({tx_data_i, tx_data_q, tx_data_valid, tx_frame_start, tx_busy, tx_underrun} !== '0) begin
            errors++;
            $display("FAIL init_outputs got %0h want 0",
                     {tx_data_i, tx_data_q, tx_data_valid, tx_frame_start, tx_busy, tx_underrun});
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL init_in_ready got %b want 1", in_ready);
        end
        sys_init = 1'b0;
        repeat (3) @(negedge clk);
        abort = 1'b0;
        frame_pos = 0; f0 = frame_starts; s0 = strobes;
        send_syms(100, 1);
        for (int c = 0; c < 2000 && frame_starts == f0; c++) @(posedge clk);
        checks++;
        if (frame_starts == f0 || first_fs_cyc - last_acc_cyc != 2) begin
            errors++;
            $display("FAIL init_latency got %0d want 2", first_fs_cyc - last_acc_cyc);
        end
        for (int c = 0; c < 4000 && strobes - s0 < SYM; c++) @(posedge clk);
        repeat (20) @(negedge clk);
        checks++;
        if (strobes - s0 != SYM || exp_q.size() != 0) begin
            errors++;
            $display("FAIL init_symbol got %0d strobes left=%0d want %0d 0", strobes - s0, exp_q.size(), SYM);
        end
    endtask

    task automatic test_async_reset();
        int s0;
        s0 = strobes;
        frame_pos = 0; abort = 1'b0;
        fork
            send_syms(0, SEQ);
        join_none
        for (int c = 0; c < 10000 && strobes - s0 < 700; c++) @(posedge clk);
        @(posedge clk);
        #2;
        sys_rstn = 1'b0; abort = 1'b1; in_data_valid = 1'b0;
        #1;
        checks++;
        if ({tx_data_i, tx_data_q, tx_data_valid, tx_frame_start, tx_busy, tx_underrun} !== '0
            || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL async_reset got %0h rdy=%b want 0 1",
                     {tx_data_i, tx_data_q, tx_data_valid, tx_frame_start, tx_busy, tx_underrun}, in_ready);
        end
        exp_q.delete();
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (tx_data_valid !== 1'b0) begin
                errors++;
                $display("FAIL async_hold got valid=%b want 0", tx_data_valid);
            end
        end
        @(posedge clk);
        #1;
        sys_rstn = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        frame_pos = 0; s0 = strobes;
        send_syms(40, 2);
        for (int c = 0; c < 8000 && strobes - s0 < 2 * SYM; c++) @(posedge clk);
        repeat (20) @(negedge clk);
        checks++;
        if (strobes - s0 != 2 * SYM || exp_q.size() != 0) begin
            errors++;
            $display("FAIL async_resume got %0d left=%0d want %0d 0", strobes - s0, exp_q.size(), 2 * SYM);
        end
    endtask

    task automatic c_send();
        logic [W-1:0] raw [CRAW];
        exp_t e;
        for (int s = 0; s < CSEQ; s++) begin
            for (int m = 0; m < CRAW; m++) begin
                raw[m] = W'(s * CRAW + m + 7);
                forever begin
                    @(negedge clk);
                    c_in_i = raw[m]; c_in_q = -raw[m]; c_in_valid = 1'b1;
                    if (c_in_ready) break;
                end
            end
            for (int n = 0; n < CSYM; n++) begin
                e.i    = (n < CCP) ? raw[CRAW - CCP + n] : raw[n - CCP];
                e.q    = -e.i;
                e.fs   = (n == 0) && (s == 0);
                e.last = (n == CSYM - 1);
                c_exp.push_back(e);
            end
        end
        @(negedge clk);
        c_in_valid = 1'b0;
    endtask

    task automatic test_osr1();
        int cnt, gaps, prev, fsn, urn;
        cnt = 0; gaps = 0; prev = 0; fsn = 0; urn = 0;
        fork
            c_send();
            for (int c = 0; c < 300; c++) begin
                exp_t e;
                @(negedge clk);
                if (c_tx_underrun) urn++;
                if (c_tx_valid) begin
                    if (cnt > 0 && cyc - prev != 1) gaps++;
                    prev = cyc;
                    cnt++;
                    if (c_tx_fs) fsn++;
                    checks++;
                    if (c_exp.size() == 0) begin
                        errors++;
                        $display("FAIL osr1_unexpected got i=%0h want no strobe", c_tx_i);
                    end else begin
                        e = c_exp.pop_front();
                        if ({c_tx_i, c_tx_q, c_tx_fs} !== {e.i, e.q, e.fs}) begin
                            errors++;
                            $display("FAIL osr1_sample got i=%0h q=%0h fs=%b want i=%0h q=%0h fs=%b",
                                     c_tx_i, c_tx_q, c_tx_fs, e.i, e.q, e.fs);
                        end
                    end
                end
            end
        join
        checks++;
        if (cnt != CSEQ * CSYM || gaps != 0) begin
            errors++;
            $display("FAIL osr1_stream got %0d strobes %0d gaps want %0d 0", cnt, gaps, CSEQ * CSYM);
        end
        checks++;
        if (fsn != 1 || urn != 0 || c_tx_busy !== 1'b0 || c_exp.size() != 0) begin
            errors++;
            $display("FAIL osr1_frame got fs=%0d ur=%0d busy=%b left=%0d want 1 0 0 0",
                     fsn, urn, c_tx_busy, c_exp.size());
        end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_underrun();
        test_osr1();
        test_init();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
